// File: rtl/symbol_ns_table.sv
// Namespaced symbol table with local, wildcard-import and export entries.
// Each request scans one namespace serially, then commits a single update.
module symbol_ns_table #(
  parameter int NS_COUNT = 2,
  parameter int DEPTH    = 8,
  parameter int KEY_W    = 16,
  parameter int PKG_W    = 4,
  localparam int NS_W    = (NS_COUNT > 1) ? $clog2(NS_COUNT) : 1,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [NS_W-1:0]       req_ns,
  input  logic [KEY_W-1:0]      req_key,
  input  logic [PKG_W-1:0]      req_pkg,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_status,
  output logic [IDX_W-1:0]      rsp_idx,
  output logic [NS_COUNT*8-1:0] conflict_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;
  typedef enum logic [1:0] {K_LOCAL, K_CAND, K_PROMO} kind_t;

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_CONF  = 3'd1;
  localparam logic [2:0] ST_DUP   = 3'd2;
  localparam logic [2:0] ST_FULL  = 3'd3;
  localparam logic [2:0] ST_BADNS = 3'd4;

  localparam logic [1:0] OP_LOCAL  = 2'd0;
  localparam logic [1:0] OP_IMPORT = 2'd1;
  localparam logic [1:0] OP_EXPORT = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [NS_W-1:0]  ns_q;
  logic [KEY_W-1:0] key_q;
  logic [PKG_W-1:0] pkg_q;
  logic             bad_q;
  logic [IDX_W-1:0] sidx_q, hit_idx_q, free_idx_q;
  logic             hit_q, free_q;
  logic [2:0]       status_q;
  logic [IDX_W-1:0] idx_q;

  logic             vld_tab  [NS_COUNT][DEPTH];
  logic [KEY_W-1:0] key_tab  [NS_COUNT][DEPTH];
  logic [PKG_W-1:0] pkg_tab  [NS_COUNT][DEPTH];
  kind_t            kind_tab [NS_COUNT][DEPTH];
  logic [7:0]       cnt_q    [NS_COUNT];

  logic             req_bad;
  logic [NS_W-1:0]  ns_s;
  logic             cur_vld, cur_match;
  kind_t            hit_kind;
  logic [PKG_W-1:0] hit_pkg;

  logic [2:0]       c_status;
  logic [IDX_W-1:0] c_idx;
  logic             c_wr, c_new, c_clr;
  kind_t            c_kind;

  assign req_bad   = int'(req_ns) >= NS_COUNT;
  // Out-of-range namespaces never touch the table, so park the index at 0.
  assign ns_s      = bad_q ? '0 : ns_q;
  assign cur_vld   = vld_tab[ns_s][sidx_q];
  assign cur_match = cur_vld && (key_tab[ns_s][sidx_q] == key_q);
  assign hit_kind  = kind_tab[ns_s][hit_idx_q];
  assign hit_pkg   = pkg_tab[ns_s][hit_idx_q];

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_status = status_q;
  assign rsp_idx    = idx_q;

  for (genvar g = 0; g < NS_COUNT; g++) begin : g_cnt
    assign conflict_cnt[g*8 +: 8] = cnt_q[g];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid)
          state_d = (req_bad || req_op == OP_CLEAR) ? COMMIT : SCAN;
      end
      SCAN: begin
        if (cur_match || sidx_q == IDX_W'(DEPTH - 1))
          state_d = COMMIT;
      end
      COMMIT: state_d = RESP;
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_status = ST_OK;
    c_idx    = '0;
    c_wr     = 1'b0;
    c_new    = 1'b0;
    c_clr    = 1'b0;
    c_kind   = K_LOCAL;
    if (bad_q) begin
      c_status = ST_BADNS;
    end else if (op_q == OP_CLEAR) begin
      c_clr = 1'b1;
    end else if (!hit_q) begin
      if (free_q) begin
        c_wr   = 1'b1;
        c_new  = 1'b1;
        c_idx  = free_idx_q;
        c_kind = (op_q == OP_LOCAL)  ? K_LOCAL :
                 (op_q == OP_IMPORT) ? K_CAND  : K_PROMO;
      end else begin
        c_status = ST_FULL;
      end
    end else begin
      c_idx = hit_idx_q;
      unique case (1'b1)
        (op_q == OP_LOCAL): begin
          if (hit_kind == K_LOCAL) begin
            c_status = ST_DUP;
          end else if (hit_kind == K_CAND) begin
            c_wr   = 1'b1;
            c_kind = K_LOCAL;
          end else begin
            c_status = ST_CONF;
          end
        end
        (op_q == OP_EXPORT): begin
          if (hit_kind == K_LOCAL || hit_pkg != pkg_q) begin
            c_status = ST_CONF;
          end else begin
            c_wr   = 1'b1;
            c_kind = K_PROMO;
          end
        end
        default: c_status = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      ns_q       <= '0;
      key_q      <= '0;
      pkg_q      <= '0;
      bad_q      <= 1'b0;
      sidx_q     <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
      status_q   <= ST_OK;
      idx_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            ns_q       <= req_ns;
            key_q      <= req_key;
            pkg_q      <= req_pkg;
            bad_q      <= req_bad;
            sidx_q     <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
          end
        end
        SCAN: begin
          if (cur_match) begin
            hit_q     <= 1'b1;
            hit_idx_q <= sidx_q;
          end else begin
            if (!cur_vld && !free_q) begin
              free_q     <= 1'b1;
              free_idx_q <= sidx_q;
            end
            sidx_q <= sidx_q + 1'b1;
          end
        end
        COMMIT: begin
          status_q <= c_status;
          idx_q    <= c_idx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NS_COUNT; n++) begin
        cnt_q[n] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          vld_tab[n][d]  <= 1'b0;
          key_tab[n][d]  <= '0;
          pkg_tab[n][d]  <= '0;
          kind_tab[n][d] <= K_LOCAL;
        end
      end
    end else if (state_q == COMMIT) begin
      if (c_clr) begin
        for (int d = 0; d < DEPTH; d++)
          vld_tab[ns_s][d] <= 1'b0;
      end else if (c_wr) begin
        vld_tab[ns_s][c_idx]  <= 1'b1;
        kind_tab[ns_s][c_idx] <= c_kind;
        if (c_new) begin
          key_tab[ns_s][c_idx] <= key_q;
          pkg_tab[ns_s][c_idx] <= pkg_q;
        end
      end
      if (c_status == ST_CONF && cnt_q[ns_s] != 8'hff)
        cnt_q[ns_s] <= cnt_q[ns_s] + 8'd1;
    end
  end

endmodule

// File: tb/tb_symbol_ns_table.sv
// Bench for symbol_ns_table: directed scenarios plus random traffic
// checked against a decision-table model of the namespaces.
module tb_symbol_ns_table;

  localparam int NS = 3;
  localparam int DP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_ns;
  logic [15:0] req_key;
  logic [3:0]  req_pkg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [2:0]  rsp_idx;
  logic [23:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;

  bit m_vld  [NS][DP];
  int m_key  [NS][DP];
  int m_pkg  [NS][DP];
  int m_kind [NS][DP];
  int m_cnt  [NS];

  always #5 clk = ~clk;

  symbol_ns_table #(
    .NS_COUNT(NS),
    .DEPTH(DP),
    .KEY_W(16),
    .PKG_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_ns(req_ns),
    .req_key(req_key),
    .req_pkg(req_pkg),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_status(rsp_status),
    .rsp_idx(rsp_idx),
    .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int n = 0; n < NS; n++) begin
      m_cnt[n] = 0;
      for (int d = 0; d < DP; d++) m_vld[n][d] = 1'b0;
    end
  endtask

  // kinds: 0 local, 1 candidate, 2 promoted
  task automatic model(input int op, ns, key, pkg,
                       output int st, idx, lat);
    int hit, fr;
    st = 0; idx = 0; lat = 2;
    if (ns >= NS) begin
      st = 4;
      return;
    end
    if (op == 3) begin
      for (int d = 0; d < DP; d++) m_vld[ns][d] = 1'b0;
      return;
    end
    hit = -1; fr = -1;
    for (int d = 0; d < DP; d++) begin
      if (m_vld[ns][d] && m_key[ns][d] == key) begin
        hit = d;
        break;
      end
      if (!m_vld[ns][d] && fr < 0) fr = d;
    end
    lat = ((hit >= 0) ? hit + 1 : DP) + 2;
    if (hit < 0) begin
      if (fr < 0) begin
        st = 3;
      end else begin
        idx = fr;
        m_vld[ns][fr]  = 1'b1;
        m_key[ns][fr]  = key;
        m_pkg[ns][fr]  = pkg;
        m_kind[ns][fr] = op;
      end
    end else begin
      idx = hit;
      case (op)
        0: begin
          if (m_kind[ns][hit] == 0) st = 2;
          else if (m_kind[ns][hit] == 1) m_kind[ns][hit] = 0;
          else st = 1;
        end
        2: begin
          if (m_kind[ns][hit] == 0 || m_pkg[ns][hit] != pkg) st = 1;
          else m_kind[ns][hit] = 2;
        end
        default: st = 0;
      endcase
    end
    if (st == 1 && m_cnt[ns] < 255) m_cnt[ns]++;
  endtask

  task automatic do_op(input int op, ns, key, pkg, hold,
                       output int gs, gi, gl);
    int es, ei, el, n;
    bit seen;
    logic [23:0] ec;
    model(op, ns, key, pkg, es, ei, el);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op[1:0];
    req_ns    = ns[1:0];
    req_key   = key[15:0];
    req_pkg   = pkg[3:0];
    rsp_ready = (hold == 0);
    @(posedge clk);
    n = 1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("rsp_timeout", seen, 1);
    gs = rsp_status;
    gi = rsp_idx;
    gl = n;
    ec = {m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
    chk("status", rsp_status, es);
    chk("idx", rsp_idx, ei);
    chk("latency", n, el);
    chk("conflict_cnt", conflict_cnt, ec);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_op    = 2'd3;
      req_ns    = 2'd0;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_status", rsp_status, gs);
      chk("hold_idx", rsp_idx, gi);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
  endtask

  int gs, gi, gl;
  bit bad_rsp;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_ns = '0;
    req_key = '0;
    req_pkg = '0;
    rsp_ready = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_status", rsp_status, 0);
    chk("rst_idx", rsp_idx, 0);
    chk("rst_cnt", conflict_cnt, 0);
    rst_n = 1'b1;

    do_op(2, 0, 5, 1, 0, gs, gi, gl);
    chk("r30_exp", gs, 0);
    do_op(0, 0, 5, 0, 0, gs, gi, gl);
    chk("r30_st", gs, 1);
    chk("r30_idx", gi, 0);
    chk("r30_cnt", conflict_cnt[7:0], 1);
    do_op(2, 1, 5, 1, 0, gs, gi, gl);
    do_op(0, 1, 5, 0, 0, gs, gi, gl);
    chk("r31_st", gs, 1);
    chk("r31_cnt", conflict_cnt[15:0], 16'h0101);

    do_op(1, 0, 9, 2, 0, gs, gi, gl);
    chk("r32_imp", gs, 0);
    do_op(0, 0, 9, 0, 0, gs, gi, gl);
    chk("r32_loc", gs, 0);
    do_op(2, 0, 9, 2, 0, gs, gi, gl);
    chk("r32_exp", gs, 1);

    do_op(3, 0, 0, 0, 0, gs, gi, gl);
    chk("clr_lat", gl, 2);
    for (int k = 1; k <= 8; k++) do_op(0, 0, k, 0, 0, gs, gi, gl);
    do_op(0, 0, 9, 0, 0, gs, gi, gl);
    chk("r33_full", gs, 3);
    chk("r33_lat", gl, 10);
    do_op(3, 0, 0, 0, 0, gs, gi, gl);
    do_op(0, 0, 9, 0, 0, gs, gi, gl);
    chk("r33_ok", gs, 0);
    chk("r33_idx", gi, 0);

    do_op(0, 3, 9, 0, 0, gs, gi, gl);
    chk("badns_st", gs, 4);
    chk("badns_lat", gl, 2);

    do_op(0, 1, 5, 0, 5, gs, gi, gl);
    do_op(0, 0, 9, 0, 0, gs, gi, gl);
    chk("hold_ignored", gs, 2);

    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd0;
    req_ns = 2'd0;
    req_key = 16'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_cnt", conflict_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    bad_rsp = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) bad_rsp = 1'b1;
    end
    chk("midrst_norsp", bad_rsp, 0);
    do_op(0, 0, 7, 0, 0, gs, gi, gl);
    chk("midrst_empty_idx", gi, 0);
    chk("midrst_empty_lat", gl, 10);

    do_op(2, 2, 50, 1, 0, gs, gi, gl);
    for (int k = 0; k < 258; k++) do_op(0, 2, 50, 0, 0, gs, gi, gl);
    chk("sat_cnt", conflict_cnt[23:16], 8'hff);

    for (int it = 0; it < 400; it++) begin
      int r, op, ns, hold;
      r = $urandom_range(0, 15);
      op = (r < 5) ? 0 : (r < 10) ? 1 : (r < 15) ? 2 : 3;
      ns = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      do_op(op, ns, $urandom_range(1, 12), $urandom_range(0, 2), hold,
            gs, gi, gl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
